// File: rtl/mult_operand_sequencer.sv
// mult_operand_sequencer
//   Sits in front of the 3x3 unsigned repeated-add multiplier. It queues
//   operand pairs, issues one GO pulse per operation, follows the
//   multiplier's busy flag and then holds {A,B,F} on a valid/ready result
//   port until it is accepted.
//
// Ports
//   SYS_CLOCK, FSM_SRESET      clock, synchronous active-high reset
//   IN_VALID/IN_READY/IN_A/B   operand pair input (IN_READY = queue not full)
//   MULT_A/B, MULT_GO          multiplier operands and one-cycle start pulse
//   MULT_BUSY, MULT_F          multiplier busy flag and product register
//   OUT_VALID/OUT_READY        result handshake
//   OUT_A/B/F                  operands and product of presented result
//   ERR_TIMEOUT                sticky abort flag, cleared only by reset
//
// Build option
//   ZERO_BYPASS_EN : a head entry with a zero operand goes straight to the
//                    result port with F=0, without touching the multiplier.
module mult_operand_sequencer #(
   parameter int OP_W       = 3,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic              SYS_CLOCK,
   input  logic              FSM_SRESET,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [OP_W-1:0]   IN_A,
   input  logic [OP_W-1:0]   IN_B,
   output logic [OP_W-1:0]   MULT_A,
   output logic [OP_W-1:0]   MULT_B,
   output logic              MULT_GO,
   input  logic              MULT_BUSY,
   input  logic [2*OP_W-1:0] MULT_F,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [OP_W-1:0]   OUT_A,
   output logic [OP_W-1:0]   OUT_B,
   output logic [2*OP_W-1:0] OUT_F,
   output logic              ERR_TIMEOUT
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_PRESENT
   } state_t;

   state_t            r_state;
   logic [OP_W-1:0]   r_fifo_a [FIFO_DEPTH];
   logic [OP_W-1:0]   r_fifo_b [FIFO_DEPTH];
   logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic [TW-1:0]     r_tmo;
   logic [OP_W-1:0]   r_mult_a, r_mult_b, r_out_a, r_out_b;
   logic [2*OP_W-1:0] r_out_f;
   logic              r_mult_go, r_out_valid, r_err;

   logic              w_full, w_empty, w_push, w_pop, w_zero, w_tmo_hit;
   logic [OP_W-1:0]   w_head_a, w_head_b;

   assign w_full    = (r_count == CW'(FIFO_DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_push    = IN_VALID & ~w_full;
   // Every exit from IDLE consumes the head, bypassed or not.
   assign w_pop     = (r_state == S_IDLE) & ~w_empty;
   assign w_head_a  = r_fifo_a[r_rd_ptr];
   assign w_head_b  = r_fifo_b[r_rd_ptr];
   assign w_tmo_hit = (r_tmo == TW'(TIMEOUT - 1));

`ifdef ZERO_BYPASS_EN
   assign w_zero = (w_head_a == '0) | (w_head_b == '0);
`else
   assign w_zero = 1'b0;
`endif

   // Queue storage: no reset needed, occupancy is tracked by r_count.
   always_ff @(posedge SYS_CLOCK) begin
      if (w_push) begin
         r_fifo_a[r_wr_ptr] <= IN_A;
         r_fifo_b[r_wr_ptr] <= IN_B;
      end
   end

   always_ff @(posedge SYS_CLOCK) begin
      if (FSM_SRESET) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge SYS_CLOCK) begin
      if (FSM_SRESET) begin
         r_state     <= S_IDLE;
         r_tmo       <= '0;
         r_mult_a    <= '0;
         r_mult_b    <= '0;
         r_mult_go   <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_a     <= '0;
         r_out_b     <= '0;
         r_out_f     <= '0;
         r_err       <= 1'b0;
      end else begin
         r_mult_go <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_tmo <= '0;
               if (!w_empty) begin
                  if (w_zero) begin
                     r_state     <= S_PRESENT;
                     r_out_valid <= 1'b1;
                     r_out_a     <= w_head_a;
                     r_out_b     <= w_head_b;
                     r_out_f     <= '0;
                  end else begin
                     r_state   <= S_ISSUE;
                     r_mult_a  <= w_head_a;
                     r_mult_b  <= w_head_b;
                     r_mult_go <= 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               r_state <= S_WAIT_BUSY;
               r_tmo   <= '0;
            end
            S_WAIT_BUSY: begin
               if (MULT_BUSY) begin
                  r_state <= S_WAIT_DONE;
                  r_tmo   <= '0;
               end else if (w_tmo_hit) begin
                  r_err   <= 1'b1;
                  r_state <= S_IDLE;
                  r_tmo   <= '0;
               end else begin
                  r_tmo <= r_tmo + 1'b1;
               end
            end
            S_WAIT_DONE: begin
               if (!MULT_BUSY) begin
                  r_state     <= S_PRESENT;
                  r_out_valid <= 1'b1;
                  r_out_a     <= r_mult_a;
                  r_out_b     <= r_mult_b;
                  r_out_f     <= MULT_F;
                  r_tmo       <= '0;
               end else if (w_tmo_hit) begin
                  r_err   <= 1'b1;
                  r_state <= S_IDLE;
                  r_tmo   <= '0;
               end else begin
                  r_tmo <= r_tmo + 1'b1;
               end
            end
            S_PRESENT: begin
               if (OUT_READY) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign IN_READY    = ~w_full;
   assign MULT_A      = r_mult_a;
   assign MULT_B      = r_mult_b;
   assign MULT_GO     = r_mult_go;
   assign OUT_VALID   = r_out_valid;
   assign OUT_A       = r_out_a;
   assign OUT_B       = r_out_b;
   assign OUT_F       = r_out_f;
   assign ERR_TIMEOUT = r_err;

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// Directed bench for mult_operand_sequencer with a behavioural repeated-add
// multiplier (busy for B+1 cycles after GO, product valid when busy drops).
module tb_mult_operand_sequencer;

   logic       SYS_CLOCK = 1'b0;
   logic       FSM_SRESET, IN_VALID, OUT_READY;
   logic       IN_READY, MULT_GO, OUT_VALID, ERR_TIMEOUT;
   logic [2:0] IN_A, IN_B, MULT_A, MULT_B, OUT_A, OUT_B;
   logic [5:0] MULT_F, OUT_F;
   logic       MULT_BUSY;

   always #5 SYS_CLOCK = ~SYS_CLOCK;

   mult_operand_sequencer dut (
      .SYS_CLOCK(SYS_CLOCK), .FSM_SRESET(FSM_SRESET),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_A(IN_A), .IN_B(IN_B),
      .MULT_A(MULT_A), .MULT_B(MULT_B), .MULT_GO(MULT_GO),
      .MULT_BUSY(MULT_BUSY), .MULT_F(MULT_F),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
      .OUT_A(OUT_A), .OUT_B(OUT_B), .OUT_F(OUT_F),
      .ERR_TIMEOUT(ERR_TIMEOUT)
   );

   // multiplier model
   logic       m_busy = 1'b0;
   logic [5:0] m_f = '0;
   logic [2:0] m_a = '0, m_b = '0;
   int         m_lat = 0;
   bit         mult_dead = 1'b0;
   assign MULT_BUSY = m_busy;
   assign MULT_F    = m_f;

   always @(posedge SYS_CLOCK) begin
      if (FSM_SRESET) begin
         m_busy <= 1'b0;
         m_f    <= '0;
         m_lat  <= 0;
      end else if (m_busy) begin
         if (m_lat <= 1) begin
            m_busy <= 1'b0;
            m_f    <= {3'b0, m_a} * {3'b0, m_b};
         end else m_lat <= m_lat - 1;
      end else if (MULT_GO === 1'b1 && !mult_dead) begin
         m_busy <= 1'b1;
         m_a    <= MULT_A;
         m_b    <= MULT_B;
         m_lat  <= int'(MULT_B) + 1;
      end
   end

   int go_cnt = 0;
   always @(posedge SYS_CLOCK) if (MULT_GO === 1'b1) go_cnt <= go_cnt + 1;

   int n_chk = 0, n_err = 0;
   logic [5:0] exp_q[$];   // {a,b} of accepted pairs in order

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock: scores a result handshake, records an accepted push.
   task automatic step();
      bit acc, hs;
      logic [5:0] e;
      acc = (IN_VALID === 1'b1) && (IN_READY === 1'b1);
      hs  = (OUT_VALID === 1'b1) && (OUT_READY === 1'b1);
      if (hs) begin
         if (exp_q.size() == 0) chk("spurious_result", 1, 0);
         else begin
            e = exp_q.pop_front();
            chk("res_a", 32'(OUT_A), 32'(e[5:3]));
            chk("res_b", 32'(OUT_B), 32'(e[2:0]));
            chk("res_f", 32'(OUT_F), 32'({3'b0, e[5:3]} * {3'b0, e[2:0]}));
         end
      end
      @(posedge SYS_CLOCK); #1;
      if (acc) begin
         exp_q.push_back({IN_A, IN_B});
         IN_VALID = 1'b0;
      end
   endtask

   task automatic wait_out(input string tag);
      int n = 0;
      while (OUT_VALID !== 1'b1 && n < 100) begin step(); n++; end
      chk(tag, 32'(OUT_VALID), 1);
   endtask

   task automatic push(input logic [2:0] a, input logic [2:0] b);
      IN_A = a; IN_B = b; IN_VALID = 1'b1;
      step();
   endtask

   initial begin
      int go0, n;
      bit stable;
      FSM_SRESET = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0; IN_A = '0; IN_B = '0;
      step(); step();
      chk("rst_out_valid", 32'(OUT_VALID), 0);
      chk("rst_go", 32'(MULT_GO), 0);
      chk("rst_err", 32'(ERR_TIMEOUT), 0);
      chk("rst_in_ready", 32'(IN_READY), 1);
      chk("rst_out_f", 32'(OUT_F), 0);
      FSM_SRESET = 1'b0;
      step();

      // basic op 7*3, GO timing
      go0 = go_cnt;
      push(3'd7, 3'd3);
      chk("go_not_early", 32'(MULT_GO), 0);
      step();
      chk("go_pulse", 32'(MULT_GO), 1);
      chk("mult_a", 32'(MULT_A), 7);
      chk("mult_b", 32'(MULT_B), 3);
      step();
      chk("go_one_cycle", 32'(MULT_GO), 0);
      wait_out("t1_valid");
      chk("t1_f", 32'(OUT_F), 21);
      chk("t1_a", 32'(OUT_A), 7);
      chk("t1_b", 32'(OUT_B), 3);

      // hold result 10 cycles with another pair queued
      stable = 1'b1;
      IN_A = 3'd2; IN_B = 3'd2; IN_VALID = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         if (!(OUT_VALID === 1'b1 && OUT_F === 6'd21 && OUT_A === 3'd7 && OUT_B === 3'd3))
            stable = 1'b0;
      end
      chk("hold_stable", 32'(stable), 1);
      chk("hold_no_go", 32'(go_cnt - go0), 1);
      OUT_READY = 1'b1;
      step();
      chk("valid_drop", 32'(OUT_VALID), 0);
      wait_out("t3_valid");
      step();
      OUT_READY = 1'b0;

      // fill the queue behind a held result
      push(3'd1, 3'd1);
      wait_out("t2_first");
      push(3'd2, 3'd3);
      push(3'd3, 3'd4);
      push(3'd4, 3'd5);
      push(3'd5, 3'd6);
      chk("full_in_ready", 32'(IN_READY), 0);
      IN_A = 3'd7; IN_B = 3'd7; IN_VALID = 1'b1;
      step(); step();
      chk("full_reject", 32'(IN_VALID & ~IN_READY), 1);
      OUT_READY = 1'b1;
      n = 0;
      while ((exp_q.size() != 0 || IN_VALID) && n < 300) begin step(); n++; end
      chk("drain_done", 32'(exp_q.size()), 0);
      step();
      OUT_READY = 1'b0;

      // timeout with dead multiplier
      mult_dead = 1'b1;
      push(3'd6, 3'd5);
      for (int i = 0; i < 17; i++) step();
      chk("tmo_not_yet", 32'(ERR_TIMEOUT), 0);
      step();
      chk("tmo_set", 32'(ERR_TIMEOUT), 1);
      void'(exp_q.pop_front());
      mult_dead = 1'b0;
      OUT_READY = 1'b1;
      go0 = go_cnt;
      push(3'd3, 3'd2);
      wait_out("tmo_next_valid");
      chk("tmo_next_f", 32'(OUT_F), 6);
      step();
      chk("tmo_sticky", 32'(ERR_TIMEOUT), 1);
      chk("tmo_next_go", 32'(go_cnt - go0), 1);

      // zero operand
      go0 = go_cnt;
      OUT_READY = 1'b0;
`ifdef ZERO_BYPASS_EN
      push(3'd5, 3'd0);
      step();
      chk("zb_valid", 32'(OUT_VALID), 1);
      chk("zb_f", 32'(OUT_F), 0);
      chk("zb_no_go", 32'(go_cnt - go0), 0);
`else
      push(3'd5, 3'd0);
      wait_out("zero_valid");
      chk("zero_f", 32'(OUT_F), 0);
      chk("zero_go", 32'(go_cnt - go0), 1);
`endif
      OUT_READY = 1'b1;
      step();
      OUT_READY = 1'b0;
      step();

      // reset in WAIT_DONE with two queued
      push(3'd1, 3'd7);
      push(3'd2, 3'd2);
      push(3'd3, 3'd3);
      step(); step();
      FSM_SRESET = 1'b1;
      step();
      chk("mid_rst_valid", 32'(OUT_VALID), 0);
      chk("mid_rst_go", 32'(MULT_GO), 0);
      chk("mid_rst_err", 32'(ERR_TIMEOUT), 0);
      chk("mid_rst_ready", 32'(IN_READY), 1);
      chk("mid_rst_mult_a", 32'(MULT_A), 0);
      FSM_SRESET = 1'b0;
      exp_q.delete();
      go0 = go_cnt;
      for (int i = 0; i < 6; i++) step();
      chk("fifo_empty_no_go", 32'(go_cnt - go0), 0);
      chk("fifo_empty_no_valid", 32'(OUT_VALID), 0);
      OUT_READY = 1'b1;
      push(3'd4, 3'd4);
      wait_out("post_rst_valid");
      chk("post_rst_f", 32'(OUT_F), 16);
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
